confreg_responder: RTL

Memory-mapped configuration-register responder on the CPU data-SRAM port, answering accesses to the 0x1faf_xxxx physical window that the CPU top remaps from 0xbfaf_xxxx. It provides LED and numeric-display output registers, a synchronized switch input, and a free-running timer with compare interrupt. It sits beside the data SRAM; an external address mux selects its read data for the window.

---
 rtl/confreg_responder_if.sv | 25 ++
 rtl/confreg_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/confreg_responder_if.sv
// Data-SRAM-style access port shared by the CPU side and the confreg responder.
// Master drives the strobe, enables, address and write data; slave returns rdata.
interface confreg_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output en,
        output wen,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  en,
        input  wen,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/confreg_responder.sv
// Config-register responder for the 0x1faf_xxxx window: LED, NUM, SWITCH, timer.
// Timer/compare/status registers exist only when CONFREG_TIMER_EN is defined.
module confreg_responder #(
    parameter logic [15:0] BASE_HI = 16'h1faf,
    parameter int          SW_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    confreg_responder_if.slave bus,
    input  logic [SW_W-1:0] switch,
    output logic [15:0]     led,
    output logic [31:0]     num,
    output logic            timer_int
);

    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_NUM    = 16'hf004;
    localparam logic [15:0] OFF_SWITCH = 16'hf008;
    localparam logic [15:0] OFF_TIMER  = 16'he000;
    localparam logic [15:0] OFF_CMP    = 16'he004;
    localparam logic [15:0] OFF_STATUS = 16'he008;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
        end
        return res;
    endfunction

    logic        hit;
    logic        wr;
    logic [15:0] off;
    logic [31:0] rd_val;
    logic [31:0] rdata;
    logic        sel_led;
    logic        sel_num;
    logic        unused_bits;

    assign off         = bus.addr[15:0];
    assign hit         = bus.en && (bus.addr[31:16] == BASE_HI);
    assign wr          = hit && (bus.wen != 4'b0000);
    assign sel_led     = (off == OFF_LED);
    assign sel_num     = (off == OFF_NUM);
    assign unused_bits = ^bus.addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 16'h0000;
        end else if (wr && sel_led) begin
            led <= {bus.wen[1] ? bus.wdata[15:8] : led[15:8],
                    bus.wen[0] ? bus.wdata[7:0]  : led[7:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num <= 32'h0;
        end else if (wr && sel_num) begin
            num <= merge(num, bus.wdata, bus.wen);
        end
    end

    // Two-flop synchronizer for the asynchronous board switches.
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

`ifdef CONFREG_TIMER_EN
    logic [31:0] timer;
    logic [31:0] timer_inc;
    logic [31:0] cmp;
    logic        pending;
    logic        sel_timer;
    logic        sel_cmp;
    logic        sel_status;
    logic        clr;

    assign sel_timer  = (off == OFF_TIMER);
    assign sel_cmp    = (off == OFF_CMP);
    assign sel_status = (off == OFF_STATUS);
    assign timer_inc  = timer + 32'd1;
    assign clr        = wr && sel_status && bus.wen[0] && bus.wdata[0];

    // Unwritten bytes keep counting so a partial load never stalls the timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= 32'h0;
        end else if (wr && sel_timer) begin
            timer <= merge(timer_inc, bus.wdata, bus.wen);
        end else begin
            timer <= timer_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp <= 32'hffff_ffff;
        end else if (wr && sel_cmp) begin
            cmp <= merge(cmp, bus.wdata, bus.wen);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (timer == cmp) begin
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

    assign timer_int = pending;
`else
    assign timer_int = 1'b0;
`endif

    // TIMER reads show the value the counter takes at the capturing edge.
    always_comb begin
        rd_val = 32'h0;
        case (off)
            OFF_LED:    rd_val = {16'h0, led};
            OFF_NUM:    rd_val = num;
            OFF_SWITCH: rd_val = 32'(sw_sync);
`ifdef CONFREG_TIMER_EN
            OFF_TIMER:  rd_val = timer_inc;
            OFF_CMP:    rd_val = cmp;
            OFF_STATUS: rd_val = {31'h0, pending};
`endif
            default:    rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'h0;
        end else if (bus.en) begin
            rdata <= hit ? rd_val : 32'h0;
        end
    end

    assign bus.rdata = rdata;

endmodule
